// File: rtl/render_sequencer.sv
// render_sequencer: control FSM feeding the game datapath.
// Sweeps the default image, shifts the song, redraws the boxes, scores, ends.
module render_sequencer #(
  parameter int GRID_W     = 240,
  parameter int GRID_H     = 180,
  parameter int BOX_SIZE   = 60,
  parameter int NUM_BOXES  = 12,
  parameter int SONG_LEN   = 59,
  parameter int HOLD_TICKS = 5000000,
  parameter int PLOT_LAT   = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] gridCounter,
  output logic [15:0] memAddressGridCounter,
  output logic        loadDefault,
  output logic        writeDefault,
  output logic        shiftSong,
  output logic [3:0]  boxCounter,
  output logic [14:0] pixelCount,
  output logic [14:0] memAddressPixelCount,
  output logic        loadX,
  output logic        loadY,
  output logic        writeToScreen,
  output logic        changeScore,
  output logic        addScore,
  output logic        songDone,
  output logic        plot,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_DEFAULT, S_SHIFT, S_DRAW,
    S_FLUSH, S_HOLD, S_BEAT, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [7:0]  gx_q, gx_d, gy_q, gy_d;
  logic [15:0] gaddr_q, gaddr_d;
  logic [7:0]  px_q, px_d;
  logic [6:0]  py_q, py_d;
  logic [14:0] paddr_q, paddr_d;
  logic [3:0]  box_q, box_d;
  logic [31:0] tick_q, tick_d;
  logic [15:0] beat_q, beat_d;
  logic [PLOT_LAT-1:0] plot_q, plot_d;

  logic grid_last, px_last, py_last, box_last;
  logic flush_last, hold_last, beat_last, plot_src;

  assign grid_last  = (gx_q == 8'(GRID_W-1)) && (gy_q == 8'(GRID_H-1));
  assign px_last    = (px_q == 8'(BOX_SIZE-1));
  assign py_last    = (py_q == 7'(BOX_SIZE-1));
  assign box_last   = (box_q == 4'(NUM_BOXES));
  assign flush_last = (tick_q == 32'(PLOT_LAT-1));
  assign hold_last  = (tick_q == 32'(HOLD_TICKS-1));
  assign beat_last  = ((beat_q + 16'd1) == 16'(SONG_LEN));

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_DEFAULT;
      S_DEFAULT: if (grid_last) state_d = S_SHIFT;
      S_SHIFT:   state_d = S_DRAW;
      S_DRAW:    if (px_last && py_last && box_last) state_d = S_FLUSH;
      S_FLUSH:   if (flush_last) state_d = S_HOLD;
      S_HOLD:    if (hold_last) state_d = S_BEAT;
      S_BEAT:    state_d = beat_last ? S_DONE : S_SHIFT;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    loadDefault   = (state_q == S_DEFAULT);
    writeDefault  = (state_q == S_DEFAULT);
    shiftSong     = (state_q == S_SHIFT);
    loadX         = (state_q == S_DRAW);
    loadY         = (state_q == S_DRAW);
    // Held through the flush so the datapath output register keeps capturing
    writeToScreen = (state_q == S_DRAW) || (state_q == S_FLUSH);
    changeScore   = (state_q == S_HOLD);
    addScore      = (state_q == S_BEAT);
    songDone      = (state_q == S_DONE);
    busy          = (state_q != S_IDLE);
  end

  always_comb begin
    gx_d    = gx_q;
    gy_d    = gy_q;
    gaddr_d = gaddr_q;
    px_d    = px_q;
    py_d    = py_q;
    paddr_d = paddr_q;
    box_d   = box_q;
    tick_d  = tick_q;
    beat_d  = beat_q;
    unique case (state_q)
      S_DEFAULT: begin
        gaddr_d = gaddr_q + 16'd1;
        if (gx_q == 8'(GRID_W-1)) begin
          gx_d = 8'd0;
          gy_d = gy_q + 8'd1;
        end else begin
          gx_d = gx_q + 8'd1;
        end
        if (grid_last) begin
          gx_d    = 8'd0;
          gy_d    = 8'd0;
          gaddr_d = 16'd0;
        end
      end
      S_SHIFT: begin
        box_d   = 4'd1;
        px_d    = 8'd0;
        py_d    = 7'd0;
        paddr_d = 15'd0;
      end
      S_DRAW: begin
        paddr_d = paddr_q + 15'd1;
        if (px_last) begin
          px_d = 8'd0;
          py_d = py_q + 7'd1;
        end else begin
          px_d = px_q + 8'd1;
        end
        if (px_last && py_last) begin
          px_d    = 8'd0;
          py_d    = 7'd0;
          paddr_d = 15'd0;
          box_d   = box_last ? 4'd0 : box_q + 4'd1;
        end
      end
      S_FLUSH: tick_d = flush_last ? 32'd0 : tick_q + 32'd1;
      S_HOLD:  tick_d = hold_last ? 32'd0 : tick_q + 32'd1;
      S_BEAT:  beat_d = beat_q + 16'd1;
      S_DONE:  beat_d = 16'd0;
      default: ;
    endcase
  end

  // Plot follows the swept pixel through the datapath's register stages
  assign plot_src = writeDefault | (writeToScreen & (state_q == S_DRAW));
  assign plot_d   = (plot_q << 1) | PLOT_LAT'(plot_src);

  always_ff @(posedge clock) begin
    if (reset) begin
      gx_q    <= '0;
      gy_q    <= '0;
      gaddr_q <= '0;
      px_q    <= '0;
      py_q    <= '0;
      paddr_q <= '0;
      box_q   <= '0;
      tick_q  <= '0;
      beat_q  <= '0;
      plot_q  <= '0;
    end else begin
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      gaddr_q <= gaddr_d;
      px_q    <= px_d;
      py_q    <= py_d;
      paddr_q <= paddr_d;
      box_q   <= box_d;
      tick_q  <= tick_d;
      beat_q  <= beat_d;
      plot_q  <= plot_d;
    end
  end

  assign gridCounter           = {gx_q, gy_q};
  assign memAddressGridCounter = gaddr_q;
  assign boxCounter            = box_q;
  assign pixelCount            = {px_q, py_q};
  assign memAddressPixelCount  = paddr_q;
  assign plot                  = plot_q[PLOT_LAT-1];

endmodule

// File: tb/tb_render_sequencer.sv
// tb_render_sequencer: scoreboard bench for render_sequencer.
// Expected per-cycle outputs are queued at start and popped each clock.
module tb_render_sequencer;

  localparam int GW = 4, GH = 3, BS = 2, NB = 12;
  localparam int SL = 3, HT = 5, PL = 3;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [15:0] gridCounter, memAddressGridCounter;
  logic        loadDefault, writeDefault, shiftSong;
  logic [3:0]  boxCounter;
  logic [14:0] pixelCount, memAddressPixelCount;
  logic        loadX, loadY, writeToScreen;
  logic        changeScore, addScore, songDone, plot, busy;

  render_sequencer #(
    .GRID_W(GW), .GRID_H(GH), .BOX_SIZE(BS), .NUM_BOXES(NB),
    .SONG_LEN(SL), .HOLD_TICKS(HT), .PLOT_LAT(PL)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .gridCounter(gridCounter),
    .memAddressGridCounter(memAddressGridCounter),
    .loadDefault(loadDefault), .writeDefault(writeDefault),
    .shiftSong(shiftSong), .boxCounter(boxCounter),
    .pixelCount(pixelCount),
    .memAddressPixelCount(memAddressPixelCount),
    .loadX(loadX), .loadY(loadY), .writeToScreen(writeToScreen),
    .changeScore(changeScore), .addScore(addScore),
    .songDone(songDone), .plot(plot), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        busy;
    logic        ld, wd, shift;
    logic [15:0] gc, ga;
    logic [3:0]  box;
    logic [14:0] pc, pa;
    logic        lx, ly, wts;
    logic        cs, as, sd;
  } rec_t;

  rec_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [79:0] obs,
                     input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic rec_t snap();
    rec_t r;
    r.busy  = busy;
    r.ld    = loadDefault;
    r.wd    = writeDefault;
    r.shift = shiftSong;
    r.gc    = gridCounter;
    r.ga    = memAddressGridCounter;
    r.box   = boxCounter;
    r.pc    = pixelCount;
    r.pa    = memAddressPixelCount;
    r.lx    = loadX;
    r.ly    = loadY;
    r.wts   = writeToScreen;
    r.cs    = changeScore;
    r.as    = addScore;
    r.sd    = songDone;
    return r;
  endfunction

  task automatic push_song();
    rec_t r;
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++) begin
        r = '0; r.busy = 1; r.ld = 1; r.wd = 1;
        r.gc = {8'(x), 8'(y)};
        r.ga = 16'(y * GW + x);
        q.push_back(r);
      end
    for (int b = 0; b < SL; b++) begin
      r = '0; r.busy = 1; r.shift = 1; q.push_back(r);
      for (int bx = 1; bx <= NB; bx++)
        for (int y = 0; y < BS; y++)
          for (int x = 0; x < BS; x++) begin
            r = '0; r.busy = 1; r.lx = 1; r.ly = 1; r.wts = 1;
            r.box = 4'(bx);
            r.pc = {8'(x), 7'(y)};
            r.pa = 15'(y * BS + x);
            q.push_back(r);
          end
      for (int i = 0; i < PL; i++) begin
        r = '0; r.busy = 1; r.wts = 1; q.push_back(r);
      end
      for (int i = 0; i < HT; i++) begin
        r = '0; r.busy = 1; r.cs = 1; q.push_back(r);
      end
      r = '0; r.busy = 1; r.as = 1; q.push_back(r);
    end
    r = '0; r.busy = 1; r.sd = 1; q.push_back(r);
    r = '0; q.push_back(r);
  endtask

  initial begin
    rec_t e;
    int idx, plots, first_plot, bad_plot;
    int n_shift, n_add, n_done;
    reset = 1'b1;
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("reset_outputs", 80'(snap()), 80'(rec_t'('0)));
    chk("reset_plot", 80'(plot), 80'd0);

    // Run into box 5, then reset together with start
    start = 1'b1;
    push_song();
    tick();
    start = 1'b0;
    for (int i = 0; i <= 30; i++) begin
      e = q.pop_front();
      chk($sformatf("pre_cyc%0d", i), 80'(snap()), 80'(e));
      if (i == 29) chk("box5_reached", 80'(boxCounter), 80'd5);
      if (i < 30) tick();
    end
    reset = 1'b1;
    start = 1'b1;
    tick();
    chk("midreset_outputs", 80'(snap()), 80'(rec_t'('0)));
    chk("midreset_plot", 80'(plot), 80'd0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("after_reset_idle", 80'(snap()), 80'(rec_t'('0)));
    q.delete();

    // Full song with a stray start pulse mid-run
    start = 1'b1;
    push_song();
    tick();
    start = 1'b0;
    idx = 0; plots = 0; first_plot = -1; bad_plot = 0;
    n_shift = 0; n_add = 0; n_done = 0;
    while (q.size() > 0 && idx < 1000) begin
      e = q.pop_front();
      chk($sformatf("cyc%0d", idx), 80'(snap()), 80'(e));
      if (plot) begin
        plots++;
        if (first_plot < 0) first_plot = idx;
        if (!e.busy || e.cs || e.as || e.sd) bad_plot++;
      end
      n_shift += int'(shiftSong);
      n_add   += int'(addScore);
      n_done  += int'(songDone);
      start = (idx == 100);
      tick();
      idx++;
    end
    start = 1'b0;
    chk("records_consumed", 80'(q.size()), 80'd0);
    chk("plot_first_idx", 80'(first_plot), 80'(PL));
    chk("plot_count", 80'(plots), 80'(GW * GH + SL * NB * BS * BS));
    chk("plot_bad_state", 80'(bad_plot), 80'd0);
    chk("shift_pulses", 80'(n_shift), 80'(SL));
    chk("add_pulses", 80'(n_add), 80'(SL));
    chk("done_pulses", 80'(n_done), 80'd1);
    repeat (3) tick();
    chk("final_idle", 80'(snap()), 80'(rec_t'('0)));
    chk("final_plot", 80'(plot), 80'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
